// File: rtl/proc_pkg.sv
// Shared datapath constants for the accumulator processor register slice.
// Default width and the clear/preset fill values.
package proc_pkg;

  localparam int DATA_W = 8;

  localparam logic [63:0] REG_ZERO = '0;
  localparam logic [63:0] REG_ONES = '1;

endpackage

// File: rtl/n_bit_ld_st_reg_gen_bit_cell.sv
// Single-bit load/store flop.
// It has an async active-low clear (dominant), an async active-low preset and a load/hold mux.
module ld_st_bit_cell (
  input  logic clk,
  input  logic clr,
  input  logic set,
  input  logic ld_str,
  input  logic d,
  output logic q
);

  logic r_q;
  logic w_next;

  // Hold path recirculates r_q, so an X on d never reaches the flop unless loading.
  assign w_next = ld_str ? d : r_q;

  always_ff @(posedge clk or negedge clr or negedge set) begin
    if (!clr)
      r_q <= 1'b0;
    else if (!set)
      r_q <= 1'b1;
    else
      r_q <= w_next;
  end

  assign q = r_q;

endmodule

// File: rtl/n_bit_ld_st_reg_gen.sv
// Generic N-bit load/store register (accumulator, instruction and address registers).
// Built from N bit cells so that each bit maps onto one set/clear flop.
module n_bit_ld_st_reg_gen
  import proc_pkg::*;
#(
  parameter int N = DATA_W
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         set,
  input  logic         ld_str,
  input  logic [N-1:0] in,
  output logic [N-1:0] out
);

  logic [N-1:0] w_q;

  for (genvar g = 0; g < N; g++) begin : g_bit
    ld_st_bit_cell u_cell (
      .clk    (clk),
      .clr    (clr),
      .set    (set),
      .ld_str (ld_str),
      .d      (in[g]),
      .q      (w_q[g])
    );
  end

  assign out = w_q;

endmodule

// File: tb/tb_n_bit_ld_st_reg_gen.sv
// Self-checking bench for n_bit_ld_st_reg_gen: 8-bit and 16-bit instances
// are checked against a value model kept as a plain variable per instance.
module tb_n_bit_ld_st_reg_gen;
  import proc_pkg::*;

  logic        clk = 1'b0;
  logic        clr = 1'b1, set = 1'b1, ld_str = 1'b0;
  logic [7:0]  in8 = '0;
  logic [7:0]  out8;
  logic        clr16 = 1'b1, set16 = 1'b1, ld16 = 1'b0;
  logic [15:0] in16 = '0;
  logic [15:0] out16;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0]  exp8;
  logic [15:0] exp16;

  always #20 clk = ~clk;

  n_bit_ld_st_reg_gen #(.N(8)) dut8 (
    .clk(clk), .clr(clr), .set(set), .ld_str(ld_str), .in(in8), .out(out8)
  );

  n_bit_ld_st_reg_gen #(.N(16)) dut16 (
    .clk(clk), .clr(clr16), .set(set16), .ld_str(ld16), .in(in16), .out(out16)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string name);
    n_tests++;
    if (out8 !== exp8) begin
      n_fail++;
      $display("FAIL %s: out=%h expected=%h at %0t", name, out8, exp8, $time);
    end
  endtask

  task automatic test_reset();
    #2;
    clr = 1'b0; set = 1'b1; ld_str = 1'b0; in8 = 8'h02;
    exp8 = 8'h00;
    #1;
    chk8("reset_immediate");
    for (int i = 0; i < 3; i++) begin
      step();
      chk8("reset_held");
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    clr = 1'b1; ld_str = 1'b0; in8 = 8'h02;
    for (int i = 0; i < 5; i++) begin
      step();
      chk8("hold_after_reset");
    end
  endtask

  task automatic test_load();
    @(negedge clk);
    ld_str = 1'b1; in8 = 8'hA5;
    #1;
    chk8("load_not_before_edge");
    exp8 = 8'hA5;
    step();
    chk8("load_a5");
    @(negedge clk);
    ld_str = 1'b0; in8 = 8'h3C;
    step();
    chk8("hold_ignores_in");
    step();
    chk8("hold_ignores_in_2");
  endtask

  task automatic test_async_set();
    @(posedge clk);
    #10;
    set = 1'b0;
    exp8 = 8'hFF;
    #1;
    chk8("async_set_immediate");
    #2;
    set = 1'b1;
    ld_str = 1'b1; in8 = 8'h12;
    #1;
    chk8("set_release_holds_ones");
    exp8 = 8'h12;
    step();
    chk8("load_after_set");
    @(negedge clk);
    ld_str = 1'b0;
  endtask

  task automatic test_priority();
    @(negedge clk);
    clr = 1'b0; set = 1'b0;
    exp8 = 8'h00;
    #1;
    chk8("clr_beats_set");
    step();
    chk8("clr_beats_set_edge");
    @(negedge clk);
    set = 1'b1;
    #1;
    clr = 1'b1;
    ld_str = 1'b1; in8 = 8'h77;
    #1;
    chk8("release_zero");
    @(posedge clk);
    #10;
    clr = 1'b0;
    #1;
    chk8("clr_mid_load");
    step();
    chk8("load_ignored_in_clr");
    step();
    chk8("load_ignored_in_clr_2");
    @(negedge clk);
    ld_str = 1'b0;
    clr = 1'b1;
    step();
    chk8("hold_after_clr_release");
  endtask

  task automatic test_random();
    int op;
    logic [7:0] d;
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 3);
      d  = 8'($urandom);
      @(negedge clk);
      case (op)
        0: begin
          ld_str = 1'b1; in8 = d;
          exp8 = d;
        end
        1: begin
          ld_str = 1'b0; in8 = d;
        end
        2: begin
          ld_str = 1'b0; in8 = d;
          set = 1'b0;
          exp8 = 8'hFF;
          #1;
          chk8("rand_set_pulse");
          #2;
          set = 1'b1;
        end
        default: begin
          ld_str = 1'b0; in8 = d;
          clr = 1'b0;
          exp8 = 8'h00;
          #1;
          chk8("rand_clr_pulse");
          #2;
          clr = 1'b1;
        end
      endcase
      step();
      chk8("rand_after_edge");
    end
    @(negedge clk);
    ld_str = 1'b0;
  endtask

  task automatic test_width();
    logic [15:0] d;
    @(negedge clk);
    clr16 = 1'b0;
    exp16 = 16'h0000;
    #1;
    n_tests++;
    if (out16 !== exp16) begin
      n_fail++;
      $display("FAIL w16_reset: out=%h expected=%h", out16, exp16);
    end
    @(negedge clk);
    clr16 = 1'b1;
    ld16 = 1'b1; in16 = 16'hBEEF;
    exp16 = 16'hBEEF;
    step();
    n_tests++;
    if (out16 !== exp16) begin
      n_fail++;
      $display("FAIL w16_load_beef: out=%h expected=%h", out16, exp16);
    end
    @(negedge clk);
    ld16 = 1'b0;
    set16 = 1'b0;
    exp16 = 16'hFFFF;
    #1;
    n_tests++;
    if (out16 !== exp16) begin
      n_fail++;
      $display("FAIL w16_set: out=%h expected=%h", out16, exp16);
    end
    #2;
    set16 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d = 16'($urandom);
      @(negedge clk);
      ld16 = ($urandom_range(0, 1) == 1);
      in16 = d;
      if (ld16) exp16 = d;
      step();
      n_tests++;
      if (out16 !== exp16) begin
        n_fail++;
        $display("FAIL w16_rand: out=%h expected=%h", out16, exp16);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_load();
    test_async_set();
    test_priority();
    test_random();
    test_width();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
